regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port write-back arbiter with in-order FIFO for a single-write-port register file
// Optional macro WB_RR_EN selects round-robin arbitration; default is fixed priority with B winning.
module regfile_wb_arbiter #(
    parameter int W     = 8,
    parameter int D     = 4,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     aValid,
    input  logic [D-1:0]             aReg,
    input  logic [W-1:0]             aData,
    output logic                     aReady,
    input  logic                     bValid,
    input  logic [D-1:0]             bReg,
    input  logic [W-1:0]             bData,
    output logic                     bReady,
    input  logic [D-1:0]             srcA,
    input  logic [D-1:0]             srcB,
    output logic                     RegWrite,
    output logic [D-1:0]             writeReg,
    output logic [W-1:0]             writeValue,
    output logic                     Stall,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [D-1:0]  fifoReg  [DEPTH];
    logic [W-1:0]  fifoData [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [CW-1:0] count;

    logic          ready, aLive, bLive, winnerIsA, firstIsA, empty;
    logic [1:0]    nLive, pushCount;
    logic [D-1:0]  firstReg, secondReg, p0Reg, p1Reg, issueReg;
    logic [W-1:0]  firstData, secondData, p0Data, p1Data, issueData;
    logic          issue, pop, push0, push1;

    // The top two registers are write-protected / hard-zero: acknowledge and drop.
    function automatic logic isDiscard(input logic [D-1:0] r);
        return r >= D'((1 << D) - 2);
    endfunction

    // Two free slots guarantee both ports can always be absorbed in one cycle.
    assign ready  = !Reset && (count <= CW'(DEPTH - 2));
    assign aReady = ready;
    assign bReady = ready;
    assign aLive  = aValid && ready && !isDiscard(aReg);
    assign bLive  = bValid && ready && !isDiscard(bReg);
    assign nLive  = {1'b0, aLive} + {1'b0, bLive};
    assign empty  = (count == '0);
    assign Count  = count;

`ifdef WB_RR_EN
    logic favorA;
    assign winnerIsA = favorA;
`else
    assign winnerIsA = 1'b0;
`endif

    assign firstIsA   = aLive && (!bLive || winnerIsA);
    assign firstReg   = firstIsA ? aReg  : bReg;
    assign firstData  = firstIsA ? aData : bData;
    assign secondReg  = firstIsA ? bReg  : aReg;
    assign secondData = firstIsA ? bData : aData;

    always_comb begin
        issue     = 1'b0;
        issueReg  = '0;
        issueData = '0;
        pop       = 1'b0;
        push0     = 1'b0;
        push1     = 1'b0;
        p0Reg     = firstReg;
        p0Data    = firstData;
        p1Reg     = secondReg;
        p1Data    = secondData;
        if (!Reset) begin
            if (!empty) begin
                issue     = 1'b1;
                issueReg  = fifoReg[rdPtr];
                issueData = fifoData[rdPtr];
                pop       = 1'b1;
                push0     = (nLive != 2'd0);
                push1     = (nLive == 2'd2);
            end else if (nLive != 2'd0) begin
                issue     = 1'b1;
                issueReg  = firstReg;
                issueData = firstData;
                push0     = (nLive == 2'd2);
                p0Reg     = secondReg;
                p0Data    = secondData;
            end
        end
    end

    assign RegWrite   = issue;
    assign writeReg   = issueReg;
    assign writeValue = issueData;
    assign pushCount  = {1'b0, push0} + {1'b0, push1};

    // Only buffered entries stall; register 15 reads are hard zero and never hazard.
    always_comb begin
        logic [PW-1:0] idx;
        Stall = 1'b0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PW'(i);
            if (!Reset && (CW'(i) < count) &&
                ((srcA != {D{1'b1}} && fifoReg[idx] == srcA) ||
                 (srcB != {D{1'b1}} && fifoReg[idx] == srcB)))
                Stall = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
`ifdef WB_RR_EN
            favorA <= 1'b1;
`endif
        end else begin
            if (push0) begin
                fifoReg[wrPtr]  <= p0Reg;
                fifoData[wrPtr] <= p0Data;
            end
            if (push1) begin
                fifoReg[wrPtr + PW'(1)]  <= p1Reg;
                fifoData[wrPtr + PW'(1)] <= p1Data;
            end
            wrPtr <= wrPtr + PW'(pushCount);
            rdPtr <= rdPtr + PW'(pop);
            count <= count + CW'(pushCount) - CW'(pop);
`ifdef WB_RR_EN
            if (aLive && bLive)
                favorA <= !favorA;
`endif
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic       CLK = 1'b0;
    logic       Reset;
    logic       aValid, bValid, aReady, bReady;
    logic [3:0] aReg, bReg, srcA, srcB, writeReg;
    logic [7:0] aData, bData, writeValue;
    logic       RegWrite, Stall;
    logic [2:0] Count;

    int checkCount = 0;
    int errorCount = 0;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(.W(8), .D(4), .DEPTH(4)) dut (
        .CLK(CLK), .Reset(Reset),
        .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
        .srcA(srcA), .srcB(srcB),
        .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
        .Stall(Stall), .Count(Count)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] ar, input logic [7:0] ad,
                         input logic bv, input logic [3:0] br, input logic [7:0] bd);
        aValid = av; aReg = ar; aData = ad;
        bValid = bv; bReg = br; bData = bd;
    endtask

    task automatic nextCycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset;
        drive(0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        nextCycle();
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int aIdx, bIdx;
        logic aAcc, bAcc;
        int expCnt [14] = '{0, 1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3, 2, 1};
        int rrReg  [6]  = '{1, 4, 5, 2, 3, 6};
        int rrDat  [6]  = '{8'hA0, 8'hB0, 8'hB1, 8'hA1, 8'hA2, 8'hB2};

        srcA = 0; srcB = 0;
        drive(0, 0, 0, 0, 0, 0);
        Reset = 1'b1;

        // reset state
        @(negedge CLK);
        checkVal("rst_regwrite", RegWrite, 0);
        checkVal("rst_aready", aReady, 0);
        checkVal("rst_bready", bReady, 0);
        checkVal("rst_stall", Stall, 0);
        nextCycle();
        Reset = 1'b0;
        @(negedge CLK);
        checkVal("rst_count", Count, 0);
        checkVal("idle_aready", aReady, 1);
        checkVal("idle_writereg", writeReg, 0);

        // single ALU write, zero latency
        nextCycle();
        drive(1, 3, 8'h5A, 0, 0, 0);
        @(negedge CLK);
        checkVal("single_regwrite", RegWrite, 1);
        checkVal("single_reg", writeReg, 3);
        checkVal("single_val", writeValue, 8'h5A);
        checkVal("single_count", Count, 0);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkVal("single_after_count", Count, 0);
        checkVal("single_after_regwrite", RegWrite, 0);

        // contention on the same register
        nextCycle();
        drive(1, 2, 8'h11, 1, 2, 8'h22);
        @(negedge CLK);
        checkVal("cont0_regwrite", RegWrite, 1);
        checkVal("cont0_reg", writeReg, 2);
`ifdef WB_RR_EN
        checkVal("cont0_val", writeValue, 8'h11);
`else
        checkVal("cont0_val", writeValue, 8'h22);
`endif
        checkVal("cont0_stall", Stall, 0);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0);
        srcA = 2;
        @(negedge CLK);
        checkVal("cont1_stall", Stall, 1);
        checkVal("cont1_count", Count, 1);
        checkVal("cont1_reg", writeReg, 2);
`ifdef WB_RR_EN
        checkVal("cont1_val", writeValue, 8'h22);
`else
        checkVal("cont1_val", writeValue, 8'h11);
`endif
        nextCycle();
        @(negedge CLK);
        checkVal("cont2_stall", Stall, 0);
        checkVal("cont2_count", Count, 0);
        checkVal("cont2_regwrite", RegWrite, 0);
        srcA = 0;

        // dropped writes to r15 / r14
        nextCycle();
        drive(1, 15, 8'hFF, 1, 14, 8'hEE);
        @(negedge CLK);
        checkVal("drop_aready", aReady, 1);
        checkVal("drop_bready", bReady, 1);
        checkVal("drop_regwrite", RegWrite, 0);
        checkVal("drop_writereg", writeReg, 0);
        checkVal("drop_writevalue", writeValue, 0);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkVal("drop_count", Count, 0);

        // reset with two buffered entries
        nextCycle();
        drive(1, 5, 8'h55, 1, 6, 8'h66);
        nextCycle();
        drive(1, 7, 8'h77, 1, 8, 8'h88);
        nextCycle();
        drive(0, 0, 0, 0, 0, 0);
        srcA = 7;
        @(negedge CLK);
        checkVal("midrst_pre_count", Count, 2);
        checkVal("midrst_pre_stall", Stall, 1);
        Reset = 1'b1;
        #1;
        checkVal("midrst_regwrite", RegWrite, 0);
        checkVal("midrst_stall", Stall, 0);
        checkVal("midrst_aready", aReady, 0);
        nextCycle();
        Reset = 1'b0;
        @(negedge CLK);
        checkVal("midrst_count", Count, 0);
        checkVal("midrst_post_regwrite", RegWrite, 0);
        checkVal("midrst_post_stall", Stall, 0);
        nextCycle();
        @(negedge CLK);
        checkVal("midrst_post2_regwrite", RegWrite, 0);
        srcA = 0;

`ifdef WB_RR_EN
        // round-robin: three contended cycles after reset
        nextCycle();
        doReset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3)
                drive(1, 4'(1 + c), 8'(8'hA0 + c), 1, 4'(4 + c), 8'(8'hB0 + c));
            else
                drive(0, 0, 0, 0, 0, 0);
            @(negedge CLK);
            if (c < 3) checkVal($sformatf("rr_ready_c%0d", c), aReady, 1);
            checkVal($sformatf("rr_regwrite_c%0d", c), RegWrite, 1);
            checkVal($sformatf("rr_reg_c%0d", c), writeReg, rrReg[c]);
            checkVal($sformatf("rr_val_c%0d", c), writeValue, rrDat[c]);
            nextCycle();
        end
        @(negedge CLK);
        checkVal("rr_end_count", Count, 0);
`else
        // fill and wrap: both producers hold requests, B wins contention
        nextCycle();
        aIdx = 0; bIdx = 0;
        for (int c = 0; c < 14; c++) begin
            drive(c < 12, 4'(aIdx), 8'(8'hA0 + aIdx), c < 12, 4'(7 + bIdx), 8'(8'hB0 + bIdx));
            @(negedge CLK);
            checkVal($sformatf("fill_count_c%0d", c), Count, expCnt[c]);
            if (c < 12) checkVal($sformatf("fill_ready_c%0d", c), aReady, (c < 3 || c % 2 == 0) ? 1 : 0);
            checkVal($sformatf("fill_regwrite_c%0d", c), RegWrite, 1);
            if (c % 2 == 0) begin
                checkVal($sformatf("fill_reg_c%0d", c), writeReg, 7 + c / 2);
                checkVal($sformatf("fill_val_c%0d", c), writeValue, 8'hB0 + c / 2);
            end else begin
                checkVal($sformatf("fill_reg_c%0d", c), writeReg, (c - 1) / 2);
                checkVal($sformatf("fill_val_c%0d", c), writeValue, 8'hA0 + (c - 1) / 2);
            end
            aAcc = aValid && aReady;
            bAcc = bValid && bReady;
            nextCycle();
            if (aAcc) aIdx++;
            if (bAcc) bIdx++;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkVal("fill_end_count", Count, 0);
        checkVal("fill_end_regwrite", RegWrite, 0);
        checkVal("fill_a_accepted", aIdx, 7);
        checkVal("fill_b_accepted", bIdx, 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
